// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle Moore control sequencer for the MIPS core.
// Steps each instruction through IF/ID/EXE/MEM/WB and drives the datapath
// enables. Outputs are combinational from the state register plus op/func/Zero.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Zero,
  output logic       PCWr,
  output logic [1:0] NPCsel,
  output logic       IRWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       ExtOp,
  output logic       ALUsrc,
  output logic [2:0] ALUctr,
  output logic       MemWr,
  output logic       MemtoReg,
  output logic       ins_done,
  output logic       ill
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;

  state_t state, next_state;

  logic is_rtype, r_ok, is_ori, is_lw, is_sw, is_beq, is_j, legal;

  // Instruction class decode from the (stable after IF) op/func fields.
  always_comb begin
    is_rtype = (op == OP_RTYPE);
    r_ok     = is_rtype && ((func == FN_ADDU) || (func == FN_SUBU) || (func == FN_SLT));
    is_ori   = (op == OP_ORI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    legal    = r_ok || is_ori || is_lw || is_sw || is_beq || is_j;
  end

  // State register; reset always restarts at instruction fetch.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IF;
    else     state <= next_state;
  end

  // Sticky illegal-instruction flag, set by a failed decode, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)                         ill <= 1'b0;
    else if (state == S_ID && !legal) ill <= 1'b1;
  end

  // Next-state and Moore control outputs; write enables gated off during reset.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    next_state = S_IF;
    PCWr       = 1'b0;
    NPCsel     = 2'b00;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    ExtOp      = 1'b0;
    ALUsrc     = 1'b0;
    ALUctr     = ALU_ADD;
    MemWr      = 1'b0;
    MemtoReg   = 1'b0;
    ins_done   = 1'b0;

    case (state)
      S_IF: begin
        IRWr       = 1'b1;
        PCWr       = 1'b1;
        next_state = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          PCWr     = 1'b1;
          NPCsel   = 2'b10;
          ins_done = 1'b1;
        end else if (!legal) begin
          ins_done = 1'b1;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (r_ok) begin
          case (func)
            FN_SUBU: ALUctr = ALU_SUB;
            FN_SLT:  ALUctr = ALU_SLT;
            default: ALUctr = ALU_ADD;
          endcase
          next_state = S_WB;
        end else if (is_ori) begin
          ALUctr     = ALU_OR;
          ALUsrc     = 1'b1;
          next_state = S_WB;
        end else if (is_lw || is_sw) begin
          ALUsrc     = 1'b1;
          ExtOp      = 1'b1;
          next_state = S_MEM;
        end else if (is_beq) begin
          ALUctr   = ALU_SUB;
          PCWr     = Zero;
          NPCsel   = 2'b01;
          ins_done = 1'b1;
        end
      end
      S_MEM: begin
        // Address computation stays stable while memory is accessed.
        ALUsrc = 1'b1;
        ExtOp  = 1'b1;
        if (is_sw) begin
          MemWr    = 1'b1;
          ins_done = 1'b1;
        end else if (is_lw) begin
          next_state = S_WB;
        end
      end
      S_WB: begin
        RegWr    = 1'b1;
        RegDst   = is_rtype;
        MemtoReg = is_lw;
        ins_done = 1'b1;
      end
      default: next_state = S_IF;
    endcase

    // Reset aborts the instruction: no architectural writes, no completion.
    if (rst) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      RegWr    = 1'b0;
      MemWr    = 1'b0;
      ins_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver pushes the hand-computed per-cycle
// control sequence of each instruction; a monitor collects the DUT outputs
// cycle by cycle and compares the whole sequence when ins_done is seen.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic       Zero;
  logic       PCWr, IRWr, RegWr, RegDst, ExtOp, ALUsrc, MemWr, MemtoReg, ins_done, ill;
  logic [1:0] NPCsel;
  logic [2:0] ALUctr;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .Zero(Zero),
    .PCWr(PCWr), .NPCsel(NPCsel), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
    .ExtOp(ExtOp), .ALUsrc(ALUsrc), .ALUctr(ALUctr), .MemWr(MemWr),
    .MemtoReg(MemtoReg), .ins_done(ins_done), .ill(ill)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               len;
    logic [4:0][13:0] vec;
    logic             ill;
  } exp_t;

  exp_t sb[$];

  // {PCWr, NPCsel, IRWr, RegWr, RegDst, ExtOp, ALUsrc, ALUctr, MemWr, MemtoReg, ins_done}
  function automatic logic [13:0] mk(input logic pcwr, input logic [1:0] npc, input logic irwr,
                                     input logic regwr, input logic regdst, input logic extop,
                                     input logic alusrc, input logic [2:0] aluctr, input logic memwr,
                                     input logic memtoreg, input logic done);
    return {pcwr, npc, irwr, regwr, regdst, extop, alusrc, aluctr, memwr, memtoreg, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: accumulate one output vector per cycle, compare at ins_done.
  logic [13:0] obs [8];
  int obs_len = 0;

  always @(negedge clk) begin
    logic [13:0] cur;
    exp_t r;
    cur = {PCWr, NPCsel, IRWr, RegWr, RegDst, ExtOp, ALUsrc, ALUctr, MemWr, MemtoReg, ins_done};
    if (rst) begin
      check("writes_in_reset", {27'd0, PCWr, IRWr, RegWr, MemWr, ins_done}, 32'd0);
      obs_len = 0;
    end else begin
      if (obs_len < 8) obs[obs_len] = cur;
      obs_len++;
      if (ins_done) begin
        if (sb.size() == 0) begin
          check("unexpected_ins_done", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          check({r.name, "_cycles"}, obs_len, r.len);
          for (int i = 0; i < r.len && i < obs_len && i < 8; i++)
            check($sformatf("%s_cyc%0d", r.name, i), {18'd0, obs[i]}, {18'd0, r.vec[i]});
          check({r.name, "_ill"}, {31'd0, ill}, {31'd0, r.ill});
        end
        obs_len = 0;
      end else if (obs_len > 6) begin
        check("runaway_instruction", obs_len, 6);
        obs_len = 0;
      end
    end
  end

  // Issue one instruction at the start of its IF cycle and wait for completion.
  task automatic issue(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int len,
                       input logic [13:0] v0, input logic [13:0] v1, input logic [13:0] v2,
                       input logic [13:0] v3, input logic [13:0] v4, input logic ill_exp);
    exp_t r;
    bit got;
    r.name = name;
    r.len  = len;
    r.vec  = {v4, v3, v2, v1, v0};
    r.ill  = ill_exp;
    sb.push_back(r);
    op   = o;
    func = f;
    Zero = z;
    got  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ins_done) begin
        got = 1;
        break;
      end
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [13:0] v_if, v_0, v_rwb, v_ldst, v_lwwb, v_swmem;

  initial begin
    v_if    = mk(1, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    v_0     = 14'd0;
    v_rwb   = mk(0, 2'b00, 0, 1, 1, 0, 0, 3'b000, 0, 0, 1);
    v_ldst  = mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 0, 0, 0);
    v_lwwb  = mk(0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 1, 1);
    v_swmem = mk(0, 2'b00, 0, 0, 0, 1, 1, 3'b000, 1, 0, 1);

    // Initial reset, then start an addu and reset it for 2 cycles while in EXE.
    rst = 1'b1; op = 6'b000000; func = 6'b100001; Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;          // IF
    @(posedge clk);         // ID
    @(posedge clk);         // EXE
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;          // first cycle after reset: IF

    issue("addu", 6'b000000, 6'b100001, 0, 4, v_if, v_0, v_0, v_rwb, v_0, 0);
    issue("subu", 6'b000000, 6'b100011, 0, 4, v_if, v_0,
          mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0), v_rwb, v_0, 0);
    issue("slt", 6'b000000, 6'b101010, 0, 4, v_if, v_0,
          mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0), v_rwb, v_0, 0);
    issue("ori", 6'b001101, 6'b000000, 0, 4, v_if, v_0,
          mk(0, 2'b00, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0),
          mk(0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 0, 1), v_0, 0);
    issue("lw", 6'b100011, 6'b000000, 0, 5, v_if, v_0, v_ldst, v_ldst, v_lwwb, 0);
    issue("sw", 6'b101011, 6'b000000, 0, 4, v_if, v_0, v_ldst, v_swmem, v_0, 0);
    issue("beq_taken", 6'b000100, 6'b000000, 1, 3, v_if, v_0,
          mk(1, 2'b01, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1), v_0, v_0, 0);
    issue("beq_not", 6'b000100, 6'b000000, 0, 3, v_if, v_0,
          mk(0, 2'b01, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1), v_0, v_0, 0);
    // Jump completes in ID.
    issue("j", 6'b000010, 6'b000000, 0, 2, v_if,
          mk(1, 2'b10, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1), v_0, v_0, v_0, 0);
    // Illegal op: ill is still clear in its own ID cycle, set afterwards.
    issue("ill_op", 6'b111111, 6'b000000, 0, 2, v_if,
          mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1), v_0, v_0, v_0, 0);
    issue("addu_after_ill", 6'b000000, 6'b100001, 0, 4, v_if, v_0, v_0, v_rwb, v_0, 1);
    issue("ill_func", 6'b000000, 6'b000000, 0, 2, v_if,
          mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1), v_0, v_0, v_0, 1);

    // Reset clears the sticky flag.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ill_cleared_by_rst", {31'd0, ill}, 32'd0);
    @(posedge clk);
    #1;
    issue("ori_after_rst", 6'b001101, 6'b000000, 0, 4, v_if, v_0,
          mk(0, 2'b00, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0),
          mk(0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 0, 1), v_0, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
